// File: rtl/pc_sequencer.sv
// Program counter stage behind the relative-jump LUT: increment, relative jump, absolute load, with IDLE/RUN/DONE run control.
// Latency: a PC update decided in cycle N is visible on prog_ctr in cycle N+1; done rises one cycle after halt.
// Backpressure: stall holds the PC for one RUN cycle (cycle_cnt still advances); there is no upstream ready.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - launch execution from address 0 (ignored while running)
//   stall             - hold PC this cycle while running
//   reljump_en        - PC <= PC + signed target
//   absjump_en        - PC <= target (wins over reljump_en)
//   halt              - stop; enter DONE with PC frozen
//   target            - jump operand (signed offset or absolute address)
//   prog_ctr          - registered program counter
//   instr_valid       - high while running (decoded from state)
//   done              - registered, held until next start or reset
//   cycle_cnt         - saturating count of RUN cycles since last start
module pc_sequencer #(
   parameter int D  = 12,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stall,
   input  logic          reljump_en,
   input  logic          absjump_en,
   input  logic          halt,
   input  logic [D-1:0]  target,
   output logic [D-1:0]  prog_ctr,
   output logic          instr_valid,
   output logic          done,
   output logic [CW-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [D-1:0]  pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      unique case (state_q)
         S_IDLE: begin
            pc_d   = '0;
            done_d = 1'b0;
            if (start) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            // Counts every RUN edge, including stalls and the halting edge.
            if (cnt_q != {CW{1'b1}}) begin
               cnt_d = cnt_q + CW'(1);
            end
            if (halt) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (absjump_en) begin
               pc_d = target;
            end else if (reljump_en) begin
               // D-bit add: two's-complement offset wraps silently both ways.
               pc_d = pc_q + target;
            end else begin
               pc_d = pc_q + D'(1);
            end
         end
         S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               pc_d    = '0;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   assign prog_ctr    = pc_q;
   assign cycle_cnt   = cnt_q;
   assign done        = done_q;
   assign instr_valid = (state_q == S_RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam int D  = 12;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset, start, stall, reljump_en, absjump_en, halt;
   logic [D-1:0]  target;
   logic [D-1:0]  prog_ctr;
   logic          instr_valid, done;
   logic [CW-1:0] cycle_cnt;

   int total = 0;
   int bad   = 0;

   pc_sequencer #(.D(D), .CW(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stall       (stall),
      .reljump_en  (reljump_en),
      .absjump_en  (absjump_en),
      .halt        (halt),
      .target      (target),
      .prog_ctr    (prog_ctr),
      .instr_valid (instr_valid),
      .done        (done),
      .cycle_cnt   (cycle_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: "running" flag, "finished" flag, integer PC and count.
   bit m_armed = 0;
   bit m_run   = 0;
   bit m_fin   = 0;
   int m_pc    = 0;
   int m_cnt   = 0;

   always @(posedge clk) begin
      int off;
      if (reset) begin
         m_armed = 1;
         m_run   = 0;
         m_fin   = 0;
         m_pc    = 0;
         m_cnt   = 0;
      end else if (m_run) begin
         if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
         if (halt) begin
            m_run = 0;
            m_fin = 1;
         end else if (stall) begin
            m_pc = m_pc;
         end else if (absjump_en) begin
            m_pc = int'(target);
         end else if (reljump_en) begin
            off  = (int'(target) >= (1 << (D - 1))) ? int'(target) - (1 << D) : int'(target);
            m_pc = (((m_pc + off) % (1 << D)) + (1 << D)) % (1 << D);
         end else begin
            m_pc = (m_pc + 1) % (1 << D);
         end
      end else if (start) begin
         m_run = 1;
         m_fin = 0;
         m_pc  = 0;
         m_cnt = 0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_armed) begin
         chk("model_pc",    int'(prog_ctr),    m_pc);
         chk("model_valid", int'(instr_valid), int'(m_run));
         chk("model_done",  int'(done),        int'(m_fin));
         chk("model_cnt",   int'(cycle_cnt),   m_cnt);
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr();
      start = 0; stall = 0; reljump_en = 0; absjump_en = 0; halt = 0; target = '0;
   endtask

   task automatic goto_pc(input int pc);
      absjump_en = 1; target = D'(pc);
      step();
      absjump_en = 0; target = '0;
   endtask

   int c0;

   initial begin
      reset = 1;
      clr();
      step(2);
      chk("rst_pc", int'(prog_ctr), 0);
      chk("rst_valid", int'(instr_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_cnt", int'(cycle_cnt), 0);

      // Idle without start stays put.
      reset = 0;
      step(2);
      chk("idle_valid", int'(instr_valid), 0);

      // Start and sequential run.
      start = 1; step(); start = 0;
      chk("start_pc", int'(prog_ctr), 0);
      chk("start_valid", int'(instr_valid), 1);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("seq_pc", int'(prog_ctr), i);
      end
      chk("seq_cnt", int'(cycle_cnt), 5);
      chk("seq_done", int'(done), 0);

      // Relative jumps.
      step(15);
      chk("at20", int'(prog_ctr), 20);
      reljump_en = 1; target = 12'hFF6; step(); clr();
      chk("rel_neg10", int'(prog_ctr), 10);
      goto_pc(4);
      reljump_en = 1; target = 12'd73; step(); clr();
      chk("rel_73", int'(prog_ctr), 77);

      // Wrap cases.
      goto_pc(3);
      reljump_en = 1; target = 12'hFFB; step(); clr();
      chk("wrap_neg", int'(prog_ctr), 4094);
      step();
      chk("seq_4095", int'(prog_ctr), 4095);
      step();
      chk("seq_wrap0", int'(prog_ctr), 0);
      goto_pc(4090);
      reljump_en = 1; target = 12'd8; step(); clr();
      chk("wrap_pos", int'(prog_ctr), 2);

      // Priority: stall over jumps, absolute over relative.
      goto_pc(30);
      c0 = int'(cycle_cnt);
      reljump_en = 1; absjump_en = 1; stall = 1; target = 12'd100; step();
      chk("stall_pc", int'(prog_ctr), 30);
      chk("stall_cnt", int'(cycle_cnt), c0 + 1);
      stall = 0; step(); clr();
      chk("abs_over_rel", int'(prog_ctr), 100);

      // Halt, then ignored inputs in DONE, then restart.
      goto_pc(42);
      halt = 1; step(); clr();
      chk("halt_done", int'(done), 1);
      chk("halt_valid", int'(instr_valid), 0);
      chk("halt_pc", int'(prog_ctr), 42);
      c0 = int'(cycle_cnt);
      reljump_en = 1; absjump_en = 1; stall = 1; halt = 1; target = 12'd7;
      step(2); clr();
      chk("done_pc_frozen", int'(prog_ctr), 42);
      chk("done_cnt_frozen", int'(cycle_cnt), c0);
      chk("done_held", int'(done), 1);
      start = 1; step(); start = 0;
      chk("restart_pc", int'(prog_ctr), 0);
      chk("restart_done", int'(done), 0);
      chk("restart_valid", int'(instr_valid), 1);
      chk("restart_cnt", int'(cycle_cnt), 0);

      // start while running has no effect.
      step(3);
      start = 1; step(); start = 0;
      chk("start_in_run_pc", int'(prog_ctr), 4);
      chk("start_in_run_cnt", int'(cycle_cnt), 4);

      // Reset mid-run overrides a pending jump.
      goto_pc(57);
      reljump_en = 1; target = 12'd5; reset = 1; step(); clr(); reset = 0;
      chk("mrst_pc", int'(prog_ctr), 0);
      chk("mrst_valid", int'(instr_valid), 0);
      chk("mrst_cnt", int'(cycle_cnt), 0);
      chk("mrst_done", int'(done), 0);
      step();
      chk("mrst_idle_pc", int'(prog_ctr), 0);

      // Cycle counter saturation under a long stall.
      start = 1; step(); start = 0;
      stall = 1; step(65540); stall = 0;
      chk("cnt_sat", int'(cycle_cnt), 65535);
      chk("sat_pc", int'(prog_ctr), 0);
      step();
      chk("cnt_sat_hold", int'(cycle_cnt), 65535);
      chk("sat_pc_inc", int'(prog_ctr), 1);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the relative-jump target lookup table.
- Holds the D-bit program counter and applies one update per cycle: sequential increment, relative jump by a signed LUT offset, or absolute load.
- Wraps the counter in a run-control FSM (IDLE/RUN/DONE) driven by the top-level start and halt signals, and counts executed cycles for the testbench.

Parameters:
- D, 12, program counter width; instruction memory holds 2^D words.
- CW, 16, width of the executed-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- start  input  1  level/pulse; launches program execution from address 0
- stall  input  1  holds PC for the current cycle while RUN
- reljump_en  input  1  take relative jump: PC <= PC + target
- absjump_en  input  1  take absolute jump: PC <= target
- halt  input  1  decoded halt instruction at current PC
- target  input  D  jump operand; two's-complement offset for relative jumps, unsigned address for absolute jumps
- prog_ctr  output  D  current program counter, addresses instruction ROM
- instr_valid  output  1  high when prog_ctr addresses an instruction to be executed this cycle
- done  output  1  program finished; held until next start or reset
- cycle_cnt  output  CW  number of RUN cycles since the last start

Behaviour:
- Reset (synchronous, active-high): state=IDLE, prog_ctr=0, done=0, instr_valid=0, cycle_cnt=0. Reset overrides every other input, including mid-RUN. The first post-reset edge with reset low follows the normal rules.
- IDLE state:
  - prog_ctr held at 0; instr_valid=0; done=0.
  - start=1 -> RUN on next edge; prog_ctr stays 0; cycle_cnt cleared to 0.
- RUN state:
  - instr_valid=1 combinationally.
  - Each edge, cycle_cnt increments (saturates at 2^CW-1), including stall cycles.
  - PC update priority: halt > stall > absjump_en > reljump_en > increment.
  - halt=1: next state DONE; prog_ctr holds; done=1 from next cycle.
  - stall=1: prog_ctr holds.
  - absjump_en=1: prog_ctr <= target. Absolute jump wins if both jump enables are high.
  - reljump_en=1: prog_ctr <= (prog_ctr + target) mod 2^D. The target is treated as signed (e.g. 12'hFF6 = -10). Wrap-around is silent in both directions.
  - Otherwise prog_ctr <= (prog_ctr + 1) mod 2^D; address 2^D-1 wraps to 0.
  - start is ignored while in RUN.
- DONE state:
  - done=1, instr_valid=0; prog_ctr and cycle_cnt frozen.
  - Jump, stall and halt inputs are ignored.
  - start=1 -> RUN on next edge, with prog_ctr=0, cycle_cnt=0, done=0.
- Latency:
  - A jump or increment decided in cycle N appears on prog_ctr in cycle N+1; there is no added pipeline delay.
  - done rises exactly one cycle after halt is sampled in RUN.
- Outputs are registered except instr_valid, which is decoded from state. Jump inputs must not create combinational paths to prog_ctr.

Test Plan:
- Reset then start, no jumps, 5 cycles -> prog_ctr 0,1,2,3,4,5 with instr_valid=1; cycle_cnt=5; done=0.
- Run to PC=20, reljump_en=1, target=12'hFF6 (-10) -> next prog_ctr=10. At PC=4, target=73 -> prog_ctr=77.
- Wrap cases:
  - PC=3, reljump_en=1, target=12'hFFB (-5) -> prog_ctr=4094.
  - Sequential from 4095 -> 0.
  - PC=4090, target=8 -> 2.
- Priority cases:
  - At PC=30, reljump_en=1 and absjump_en=1 with target=100 -> prog_ctr=100.
  - Same inputs plus stall=1 -> prog_ctr stays 30; cycle_cnt still increments.
- Halt at PC=42 -> next cycle done=1, instr_valid=0, prog_ctr=42. Toggling jump inputs changes nothing. start=1 -> prog_ctr=0, done=0, RUN resumes.
- reset=1 asserted mid-RUN at PC=57 with reljump_en=1 -> next edge prog_ctr=0, state IDLE, cycle_cnt=0, done=0. start during RUN without reset has no effect.
